// File: rtl/lnet_layer_sequencer_pkg.sv
// Shared constants and FSM encoding for the time-multiplexed LogicNets layer sequencer.
// The sequencer and its shared lookup datapath both import this package.
package lnet_pkg;

  localparam int DEFAULT_FAN_IN = 6;

  localparam logic CFG_SEL_TT   = 1'b0;
  localparam logic CFG_SEL_CONN = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/lnet_layer_sequencer_neuron_lookup.sv
// Combinational gather + truth-table lookup for a single LogicNets neuron.
// Address bit k is the input bit selected by connectivity index k; out-of-range indices read 0.
module lnet_neuron_lookup
  import lnet_pkg::*;
#(
  parameter int IN_WIDTH = 16,
  parameter int FAN_IN   = DEFAULT_FAN_IN,
  parameter int IDX_W    = $clog2(IN_WIDTH)
) (
  input  logic [IN_WIDTH-1:0]     in_vec,
  input  logic [FAN_IN*IDX_W-1:0] conn,
  input  logic [(2**FAN_IN)-1:0]  tt,
  output logic                    out_bit
);

  localparam int             PAD_W     = 2 ** IDX_W;
  localparam logic [IDX_W:0] IDX_LIMIT = (IDX_W + 1)'(IN_WIDTH);

  logic [PAD_W-1:0]  in_pad;
  logic [FAN_IN-1:0] addr;

  // Zero-extend so every encodable index selects a defined bit.
  assign in_pad = PAD_W'(in_vec);

  for (genvar gi = 0; gi < FAN_IN; gi++) begin : g_gather
    logic [IDX_W-1:0] idx;
    logic             in_range;
    assign idx      = conn[gi*IDX_W +: IDX_W];
    assign in_range = ({1'b0, idx} < IDX_LIMIT);
    assign addr[gi] = in_range & in_pad[idx];
  end

  assign out_bit = tt[addr];

endmodule

// File: rtl/lnet_layer_sequencer.sv
// Sequential evaluator for one LogicNets sparse layer: one neuron per cycle through a
// single shared lookup, tables loaded through a configuration port while idle.
module lnet_layer_sequencer
  import lnet_pkg::*;
#(
  parameter int IN_WIDTH    = 16,
  parameter int NUM_NEURONS = 8,
  parameter int FAN_IN      = DEFAULT_FAN_IN,
  parameter int IDX_W       = $clog2(IN_WIDTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_we,
  input  logic                           cfg_sel,
  input  logic [$clog2(NUM_NEURONS)-1:0] cfg_addr,
  input  logic [(2**FAN_IN)-1:0]         cfg_data,
  output logic                           cfg_ready,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [IN_WIDTH-1:0]            s_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [NUM_NEURONS-1:0]         m_data,
  output logic                           busy
);

  localparam int               TT_W   = 2 ** FAN_IN;
  localparam int               CONN_W = FAN_IN * IDX_W;
  localparam int               CNT_W  = $clog2(NUM_NEURONS);
  localparam logic [CNT_W-1:0] LAST_N = CNT_W'(NUM_NEURONS - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IN_WIDTH-1:0]    in_q, in_d;
  logic [NUM_NEURONS-1:0] result_q, result_d;
  logic [TT_W-1:0]        tt_q   [NUM_NEURONS];
  logic [TT_W-1:0]        tt_d   [NUM_NEURONS];
  logic [CONN_W-1:0]      conn_q [NUM_NEURONS];
  logic [CONN_W-1:0]      conn_d [NUM_NEURONS];
  logic                   cfg_wr;
  logic                   lut_bit;

  // Writes are only honoured while idle; during EVAL/HOLD they are silently dropped.
  assign cfg_wr = cfg_we && (state_q == IDLE);

  always_comb begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      tt_d[i]   = tt_q[i];
      conn_d[i] = conn_q[i];
      if (cfg_wr && (cfg_addr == CNT_W'(i))) begin
        if (cfg_sel == CFG_SEL_CONN) begin
          conn_d[i] = cfg_data[CONN_W-1:0];
        end else begin
          tt_d[i] = cfg_data;
        end
      end
    end
  end

  lnet_neuron_lookup #(
    .IN_WIDTH (IN_WIDTH),
    .FAN_IN   (FAN_IN),
    .IDX_W    (IDX_W)
  ) u_lookup (
    .in_vec  (in_q),
    .conn    (conn_q[cnt_q]),
    .tt      (tt_q[cnt_q]),
    .out_bit (lut_bit)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_d     = in_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (s_valid) begin
          in_d     = s_data;
          result_d = '0;
          cnt_d    = '0;
          state_d  = EVAL;
        end
      end
      EVAL: begin
        result_d[cnt_q] = lut_bit;
        if (cnt_q == LAST_N) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (m_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      in_q     <= '0;
      result_q <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        tt_q[i]   <= '0;
        conn_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      in_q     <= in_d;
      result_q <= result_d;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        tt_q[i]   <= tt_d[i];
        conn_q[i] <= conn_d[i];
      end
    end
  end

  assign s_ready   = (state_q == IDLE);
  assign cfg_ready = (state_q == IDLE);
  assign m_valid   = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign m_data    = result_q;

endmodule

// File: tb/tb_lnet_layer_sequencer.sv
// Scoreboard bench for lnet_layer_sequencer: directed vectors push expected results,
// per-instance monitors pop and compare on each output handshake.
module tb_lnet_layer_sequencer;
  import lnet_pkg::*;

  localparam int NN = 8;

  typedef struct {
    logic [7:0] d;
    string      n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  // Main instance, IN_WIDTH = 16
  logic        cfg_we = 1'b0, cfg_sel = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [63:0] cfg_data = '0;
  logic        cfg_ready, s_ready, m_valid, busy;
  logic        s_valid = 1'b0, m_ready = 1'b1;
  logic [15:0] s_data = '0;
  logic [7:0]  m_data;

  // Second instance, IN_WIDTH = 12, for out-of-range indices
  logic        x_cfg_we = 1'b0, x_cfg_sel = 1'b0;
  logic [2:0]  x_cfg_addr = '0;
  logic [63:0] x_cfg_data = '0;
  logic        x_cfg_ready, x_s_ready, x_m_valid, x_busy;
  logic        x_s_valid = 1'b0, x_m_ready = 1'b1;
  logic [11:0] x_s_data = '0;
  logic [7:0]  x_m_data;

  exp_t exp_q[$];
  exp_t x_exp_q[$];
  int   acc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lnet_layer_sequencer u_dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
  );

  lnet_layer_sequencer #(.IN_WIDTH(12)) u_dut12 (
    .clk(clk), .rst(rst), .cfg_we(x_cfg_we), .cfg_sel(x_cfg_sel), .cfg_addr(x_cfg_addr),
    .cfg_data(x_cfg_data), .cfg_ready(x_cfg_ready), .s_valid(x_s_valid), .s_ready(x_s_ready),
    .s_data(x_s_data), .m_valid(x_m_valid), .m_ready(x_m_ready), .m_data(x_m_data), .busy(x_busy)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [63:0] mk_conn(input logic [3:0] i0, i1, i2, i3, i4, i5);
    return {40'd0, i5, i4, i3, i2, i1, i0};
  endfunction

  // Main monitor: latency, hold stability, no s_ready in HOLD, data on handshake.
  logic       prev_mv = 1'b0;
  logic [7:0] hold_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      acc_q.delete();
      prev_mv = 1'b0;
    end else begin
      if (s_valid && s_ready) acc_q.push_back(cyc + 1);
      if (m_valid && !prev_mv) begin
        if (acc_q.size() == 0) check("unexpected_m_valid", {24'd0, m_data}, 32'hFFFF_FFFF);
        else check("latency", cyc - acc_q.pop_front(), NN);
        hold_data = m_data;
      end
      if (m_valid && prev_mv) check("hold_stable", {24'd0, m_data}, {24'd0, hold_data});
      if (m_valid) check("hold_s_ready", {31'd0, s_ready}, 0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {24'd0, m_data}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check(e.n, {24'd0, m_data}, {24'd0, e.d});
        end
      end
      prev_mv = m_valid;
    end
  end

  always @(negedge clk) begin
    if (!rst && x_m_valid && x_m_ready) begin
      if (x_exp_q.size() == 0) begin
        check("x_unexpected_output", {24'd0, x_m_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = x_exp_q.pop_front();
        check(e.n, {24'd0, x_m_data}, {24'd0, e.d});
      end
    end
  end

  task automatic cfg_write(input logic sel, input logic [2:0] a, input logic [63:0] d);
    int w = 0;
    while (!cfg_ready && w < 100) begin @(posedge clk); #1; w++; end
    check("cfg_ready_wait", {31'd0, cfg_ready}, 1);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic [7:0] e, input string nm, input bit push);
    int w = 0;
    exp_t x;
    while (!s_ready && w < 100) begin @(posedge clk); #1; w++; end
    if (!s_ready) check({nm, "_accept_timeout"}, {31'd0, s_ready}, 1);
    x.d = e; x.n = nm;
    s_valid = 1'b1; s_data = d;
    if (push) exp_q.push_back(x);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic x_cfg_write(input logic sel, input logic [2:0] a, input logic [63:0] d);
    x_cfg_we = 1'b1; x_cfg_sel = sel; x_cfg_addr = a; x_cfg_data = d;
    @(posedge clk); #1;
    x_cfg_we = 1'b0;
  endtask

  task automatic x_send(input logic [11:0] d, input logic [7:0] e, input string nm);
    int w = 0;
    exp_t x;
    while (!x_s_ready && w < 100) begin @(posedge clk); #1; w++; end
    if (!x_s_ready) check({nm, "_accept_timeout"}, {31'd0, x_s_ready}, 1);
    x.d = e; x.n = nm;
    x_s_valid = 1'b1; x_s_data = d;
    x_exp_q.push_back(x);
    @(posedge clk); #1;
    x_s_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int w = 0;
    while ((exp_q.size() != 0 || x_exp_q.size() != 0) && w < 200) begin @(posedge clk); #1; w++; end
    check({nm, "_drain"}, exp_q.size() + x_exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_s_ready", {31'd0, s_ready}, 1);
    check("rst_cfg_ready", {31'd0, cfg_ready}, 1);
    check("rst_m_valid", {31'd0, m_valid}, 0);
    check("rst_m_data", {24'd0, m_data}, 0);
    check("rst_busy", {31'd0, busy}, 0);

    // Out-of-range index on the 12-bit instance: index 14 reads 0, index 11 is live.
    x_cfg_write(CFG_SEL_CONN, 3'd1, mk_conn(4'd14, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5));
    x_cfg_write(CFG_SEL_TT,   3'd1, 64'h1);
    x_cfg_write(CFG_SEL_CONN, 3'd2, mk_conn(4'd11, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5));
    x_cfg_write(CFG_SEL_TT,   3'd2, 64'h2);
    x_send(12'hFC1, 8'h06, "oor_fc1");
    x_send(12'h000, 8'h02, "oor_000");

    // Single in-range neuron: only address 23 set.
    cfg_write(CFG_SEL_TT,   3'd0, 64'h0000_0000_0080_0000);
    cfg_write(CFG_SEL_CONN, 3'd0, mk_conn(4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5));
    send(16'h0017, 8'h01, "n0_hit", 1);
    check("eval_busy", {31'd0, busy}, 1);
    check("eval_cfg_ready", {31'd0, cfg_ready}, 0);
    send(16'h0016, 8'h00, "n0_miss", 1);

    // Reversed connectivity on neuron 3: only address 63 set.
    cfg_write(CFG_SEL_CONN, 3'd3, mk_conn(4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10));
    cfg_write(CFG_SEL_TT,   3'd3, 64'h8000_0000_0000_0000);
    send(16'hFC00, 8'h08, "n3_hit", 1);
    send(16'h7C00, 8'h00, "n3_miss", 1);
    send(16'hFC17, 8'h09, "n0_n3_hit", 1);
    drain("basic");

    // Backpressure: hold result, attempt writes that must be dropped.
    m_ready = 1'b0;
    send(16'h0017, 8'h01, "bp_hold", 1);
    w = 0;
    while (!m_valid && w < 50) begin @(posedge clk); #1; w++; end
    check("bp_m_valid", {31'd0, m_valid}, 1);
    for (int i = 0; i < 5; i++) begin
      cfg_we = 1'b1; cfg_sel = CFG_SEL_TT; cfg_addr = 3'd0; cfg_data = '1;
      check("bp_cfg_ready", {31'd0, cfg_ready}, 0);
      check("bp_busy", {31'd0, busy}, 1);
      @(posedge clk); #1;
    end
    cfg_we = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_m_valid", {31'd0, m_valid}, 0);
    check("bp_release_s_ready", {31'd0, s_ready}, 1);
    send(16'h0016, 8'h00, "bp_readback", 1);
    drain("bp");

    // Reset at counter 4 abandons the transaction and clears tables.
    send(16'h0017, 8'h00, "rst_eval", 0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < NN + 4; i++) begin
      check("rst_no_m_valid", {31'd0, m_valid}, 0);
      @(posedge clk); #1;
    end
    send(16'h0017, 8'h00, "post_rst_n0", 1);
    send(16'hFC00, 8'h00, "post_rst_n3", 1);
    drain("rst");

    // Write and accept in the same IDLE cycle: new table is used.
    w = 0;
    while (!s_ready && w < 100) begin @(posedge clk); #1; w++; end
    begin
      exp_t x;
      x.d = 8'h01; x.n = "cfg_and_accept";
      cfg_we = 1'b1; cfg_sel = CFG_SEL_TT; cfg_addr = 3'd0; cfg_data = '1;
      s_valid = 1'b1; s_data = 16'h0000;
      exp_q.push_back(x);
      @(posedge clk); #1;
      cfg_we = 1'b0; s_valid = 1'b0;
    end
    drain("simul");

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
